// File: rtl/vgaconsole_glyph_shifter.sv
// vgaconsole_glyph_shifter
// Per-line pixel serializer for the VGA text console. Fetches each cell's
// character code from the text buffer, drives it to the character ROM,
// slices the active 5-pixel glyph row and shifts it out at the pixel rate
// with a blank spacing column appended per cell.
// Optional feature macro: VGACONSOLE_CURSOR_EN (inverted cursor cell).
module vgaconsole_glyph_shifter #(
    parameter int COLS       = 10,
    parameter int PIX_REPEAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     line_start,
    input  logic [2:0]               glyph_row,
    output logic                     col_rd,
    output logic [$clog2(COLS)-1:0]  col_addr,
    input  logic [6:0]               char_code,
    output logic [6:0]               rom_addr,
    input  logic [34:0]              rom_data,
    output logic                     pix,
    output logic                     pix_active,
    output logic                     line_done
`ifdef VGACONSOLE_CURSOR_EN
    ,
    input  logic [$clog2(COLS)-1:0]  cursor_col,
    input  logic                     cursor_on
`endif
);

    localparam int COL_W = $clog2(COLS);
    localparam int SUB_W = (PIX_REPEAT > 1) ? $clog2(PIX_REPEAT) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, ACTIVE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SUB_W-1:0]   r_sub_cnt;
    logic [2:0]         r_px_cnt;
    logic [COL_W-1:0]   r_col_cnt;
    logic [2:0]         r_row_q;
    logic               r_col_rd;
    logic [COL_W-1:0]   r_col_addr;
    logic [6:0]         r_rom_addr;
    logic               r_cap_p1;
    logic               r_cap_p2;
    logic [4:0]         r_next_bits;
    logic [5:0]         r_shreg;
    logic               r_pix_active;
    logic               r_line_done;

    logic               w_sub_wrap;
    logic               w_px_wrap;
    logic               w_col_last;
    logic               w_line_end;
    logic [COL_W-1:0]   w_col_next;
    logic [4:0]         w_slice;
    logic               w_inv_first;
    logic               w_inv_next;

    // Row 7 is the inter-line gap; otherwise pick row's 5 bits, MSB = leftmost.
    function automatic logic [4:0] row_slice(input logic [34:0] bitmap, input logic [2:0] row);
        logic [34:0] shifted;
        shifted = bitmap << (5 * int'(row));
        if (row == 3'd7) return 5'd0;
        return shifted[34:30];
    endfunction

    // Cell word: glyph bits followed by the spacing column, optionally inverted.
    function automatic logic [5:0] cell_word(input logic [4:0] bits, input logic inv);
        return {bits, 1'b0} ^ {6{inv}};
    endfunction

    assign w_sub_wrap = (r_sub_cnt == SUB_W'(PIX_REPEAT - 1));
    assign w_px_wrap  = (r_px_cnt == 3'd5);
    assign w_col_last = (r_col_cnt == COL_W'(COLS - 1));
    assign w_line_end = (r_state == ACTIVE) && w_sub_wrap && w_px_wrap && w_col_last;
    assign w_col_next = r_col_cnt + COL_W'(1);
    assign w_slice    = row_slice(rom_data, r_row_q);

`ifdef VGACONSOLE_CURSOR_EN
    assign w_inv_first = cursor_on && (cursor_col == '0);
    assign w_inv_next  = cursor_on && (cursor_col == w_col_next);
`else
    assign w_inv_first = 1'b0;
    assign w_inv_next  = 1'b0;
`endif

    assign col_rd     = r_col_rd;
    assign col_addr   = r_col_addr;
    assign rom_addr   = r_rom_addr;
    assign pix        = r_shreg[5];
    assign pix_active = r_pix_active;
    assign line_done  = r_line_done;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; a line_start pulse always (re)starts the prefetch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (line_start) w_state_nxt = FETCH;
            FETCH:   if (line_start) w_state_nxt = FETCH;
                     else if (r_cap_p2) w_state_nxt = ACTIVE;
            ACTIVE:  if (line_start) w_state_nxt = FETCH;
                     else if (w_line_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Fetch pipeline, counters and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_rd     <= 1'b0;
            r_col_addr   <= '0;
            r_rom_addr   <= '0;
            r_cap_p1     <= 1'b0;
            r_cap_p2     <= 1'b0;
            r_shreg      <= '0;
            r_pix_active <= 1'b0;
            r_line_done  <= 1'b0;
            r_sub_cnt    <= '0;
            r_px_cnt     <= '0;
            r_col_cnt    <= '0;
        end else begin
            r_col_rd    <= 1'b0;
            r_line_done <= 1'b0;
            // Buffer data arrives the cycle after col_rd; ROM data the cycle after that.
            r_cap_p1    <= r_col_rd;
            r_cap_p2    <= r_cap_p1;
            if (r_cap_p1) r_rom_addr <= char_code;

            if (line_start) begin
                // Abort/restart: drop in-flight fetches and blank the output.
                r_col_rd     <= 1'b1;
                r_col_addr   <= '0;
                r_cap_p1     <= 1'b0;
                r_cap_p2     <= 1'b0;
                r_shreg      <= '0;
                r_pix_active <= 1'b0;
                r_sub_cnt    <= '0;
                r_px_cnt     <= '0;
                r_col_cnt    <= '0;
            end else begin
                case (r_state)
                    FETCH: begin
                        if (r_cap_p2) begin
                            // Cell 0 loads straight from the ROM slice as it lands.
                            r_shreg      <= cell_word(w_slice, w_inv_first);
                            r_pix_active <= 1'b1;
                            r_sub_cnt    <= '0;
                            r_px_cnt     <= '0;
                            r_col_cnt    <= '0;
                            if (COLS > 1) begin
                                r_col_rd   <= 1'b1;
                                r_col_addr <= COL_W'(1);
                            end
                        end
                    end
                    ACTIVE: begin
                        if (w_sub_wrap) begin
                            r_sub_cnt <= '0;
                            if (w_px_wrap) begin
                                r_px_cnt <= '0;
                                if (w_col_last) begin
                                    r_col_cnt    <= '0;
                                    r_shreg      <= '0;
                                    r_pix_active <= 1'b0;
                                    r_line_done  <= 1'b1;
                                end else begin
                                    r_col_cnt <= w_col_next;
                                    r_shreg   <= cell_word(r_next_bits, w_inv_next);
                                    if (int'(w_col_next) < COLS - 1) begin
                                        r_col_rd   <= 1'b1;
                                        r_col_addr <= w_col_next + COL_W'(1);
                                    end
                                end
                            end else begin
                                r_px_cnt <= r_px_cnt + 3'd1;
                                r_shreg  <= {r_shreg[4:0], 1'b0};
                            end
                        end else begin
                            r_sub_cnt <= r_sub_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Data-only registers: glyph row and the prefetched slice for the next cell.
    always_ff @(posedge clk) begin
        if (line_start) r_row_q <= glyph_row;
        if (r_cap_p2)   r_next_bits <= w_slice;
    end

endmodule

// File: tb/tb_vgaconsole_glyph_shifter.sv
// Self-checking bench for vgaconsole_glyph_shifter (COLS=10, PIX_REPEAT=4).
module tb_vgaconsole_glyph_shifter;

    localparam int COLS  = 10;
    localparam int PR    = 4;
    localparam int CELL  = 6 * PR;
    localparam int LINE  = COLS * CELL;
    localparam int COL_W = $clog2(COLS);
    localparam int FULL  = 4 + LINE + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             line_start;
    logic [2:0]       glyph_row;
    logic             col_rd;
    logic [COL_W-1:0] col_addr;
    logic [6:0]       char_code = '0;
    logic [6:0]       rom_addr;
    logic [34:0]      rom_data;
    logic             pix;
    logic             pix_active;
    logic             line_done;
`ifdef VGACONSOLE_CURSOR_EN
    logic [COL_W-1:0] cursor_col = '0;
    logic             cursor_on  = 1'b0;
`endif

    logic [6:0]  codes [COLS];
    logic [34:0] rom_table [128];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  row;
        logic [34:0] word;
        logic [5:0]  exp;
    } vec_t;
    vec_t vecs [7];

    vgaconsole_glyph_shifter #(.COLS(COLS), .PIX_REPEAT(PR)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .glyph_row  (glyph_row),
        .col_rd     (col_rd),
        .col_addr   (col_addr),
        .char_code  (char_code),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix        (pix),
        .pix_active (pix_active),
        .line_done  (line_done)
`ifdef VGACONSOLE_CURSOR_EN
        ,
        .cursor_col (cursor_col),
        .cursor_on  (cursor_on)
`endif
    );

    always #5 clk = ~clk;

    // Text buffer stub: data one cycle after the read strobe.
    always @(posedge clk) if (col_rd) char_code <= codes[col_addr];

    // Character ROM stub.
    assign rom_data = rom_table[rom_addr];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference pixel i of the line: cell i/CELL, pixel (i%CELL)/PR; pixel 5 is spacing.
    function automatic logic exp_pixel(input logic [2:0] row, input int i);
        int          c;
        int          p;
        logic [34:0] w;
        logic [4:0]  bits;
        c = i / CELL;
        p = (i % CELL) / PR;
        if (row == 3'd7 || p == 5) return 1'b0;
        w = rom_table[codes[c]] >> (30 - 5 * int'(row));
        bits = w[4:0];
        return bits[4 - p];
    endfunction

    // Pulse line_start in the current cycle and check cycles 1..stop_at after it.
    task automatic run_line(input logic [2:0] row, input int stop_at, output logic [5:0] cell0);
        logic             ea, ep, ed, erd;
        logic [COL_W-1:0] eaddr;
        cell0      = '0;
        line_start = 1'b1;
        glyph_row  = row;
        for (int cyc = 1; cyc <= stop_at; cyc++) begin
            @(posedge clk);
            #1;
            line_start = 1'b0;
            ea = (cyc >= 4) && (cyc < 4 + LINE);
            ep = ea ? exp_pixel(row, cyc - 4) : 1'b0;
            ed = (cyc == 4 + LINE);
            chk("active_pix_done", {61'd0, pix_active, pix, line_done}, {61'd0, ea, ep, ed});
            erd   = 1'b0;
            eaddr = '0;
            if (cyc == 1) begin
                erd = 1'b1;
            end else if (cyc >= 4 && (cyc - 4) % CELL == 0 && (cyc - 4) / CELL < COLS - 1) begin
                erd   = 1'b1;
                eaddr = COL_W'((cyc - 4) / CELL + 1);
            end
            chk("col_rd", {63'd0, col_rd}, {63'd0, erd});
            if (erd) chk("col_addr", 64'(col_addr), 64'(eaddr));
            if (cyc == 3)
                chk("rom_addr_col0", 64'(rom_addr), 64'(codes[0]));
            else if (cyc >= 6 && (cyc - 6) % CELL == 0 && (cyc - 6) / CELL < COLS - 1)
                chk("rom_addr_next", 64'(rom_addr), 64'(codes[(cyc - 6) / CELL + 1]));
            if (cyc >= 4 && cyc < 4 + CELL && (cyc - 4) % PR == 0)
                cell0[5 - (cyc - 4) / PR] = pix;
        end
    endtask

    initial begin
        logic [5:0]  cell0;
        logic [63:0] rnd;
        logic        bad;

        vecs[0] = '{3'd0, 35'h11 << 30, 6'b100010};
        vecs[1] = '{3'd7, ~35'd0, 6'b000000};
        vecs[2] = '{3'd6, {30'h3FFF_FFFF, 5'b01011}, 6'b010110};
        vecs[3] = '{3'd3, 35'h1F << 15, 6'b111110};
        vecs[4] = '{3'd2, ~(35'h1F << 20) | (35'h14 << 20), 6'b101000};
        vecs[5] = '{3'd1, 35'h1F << 30, 6'b000000};
        vecs[6] = '{3'd4, 35'h01 << 10, 6'b000010};

        for (int a = 0; a < 128; a++) rom_table[a] = '0;
        for (int c = 0; c < COLS; c++) codes[c] = '0;
        rst        = 1'b1;
        line_start = 1'b0;
        glyph_row  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {48'd0, col_rd, 4'(col_addr), rom_addr, pix, pix_active, line_done},
            64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fixed glyph-row vectors: every cell uses the same bitmap.
        for (int v = 0; v < 7; v++) begin
            for (int c = 0; c < COLS; c++) begin
                codes[c] = 7'(64 + c);
                rom_table[64 + c] = vecs[v].word;
            end
            run_line(vecs[v].row, FULL, cell0);
            chk("cell0_pattern", 64'(cell0), 64'(vecs[v].exp));
        end

        // Control codes pass straight through to the ROM address.
        for (int c = 0; c < COLS; c++) codes[c] = 7'(c + 3);
        run_line(3'd0, FULL, cell0);

        // Randomized text and bitmaps.
        for (int a = 32; a < 128; a++) begin
            rnd = {$urandom(), $urandom()};
            rom_table[a] = rnd[34:0];
        end
        for (int n = 0; n < 6; n++) begin
            for (int c = 0; c < COLS; c++) codes[c] = 7'($urandom_range(0, 127));
            run_line(3'($urandom_range(0, 7)), FULL, cell0);
        end

        // Abort 50 cycles into a line, then a full restarted line.
        run_line(3'd1, 50, cell0);
        run_line(3'd2, FULL, cell0);

        // Restart coinciding with the last active clock suppresses line_done.
        run_line(3'd3, 3 + LINE, cell0);
        run_line(3'd4, FULL, cell0);

        // Reset in the middle of a line.
        run_line(3'd5, 100, cell0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midline_reset", {57'd0, col_rd, pix, pix_active, line_done, 3'd0},
            64'd0);
        chk("midline_reset_rom_addr", 64'(rom_addr), 64'd0);
        rst = 1'b0;
        bad = 1'b0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (pix_active || line_done || col_rd || pix) bad = 1'b1;
        end
        chk("idle_after_reset", {63'd0, bad}, 64'd0);
        run_line(3'd0, FULL, cell0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
